// File: rtl/cmos_cap_pkg.sv
// Shared types and constants for the camera capture front-end.
package cmos_cap_pkg;

  // Capture control states: idle, skipping settling frames, capturing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } cap_state_t;

  // Decimation selector encoding (both axes).
  localparam logic [1:0] DECIM_NONE  = 2'd0;  // keep every pixel
  localparam logic [1:0] DECIM_2     = 2'd1;  // keep every 2nd
  localparam logic [1:0] DECIM_4     = 2'd2;  // keep every 4th
  localparam logic [1:0] DECIM_4_ALT = 2'd3;  // aliases DECIM_4

  // Default coordinate / crop field width.
  localparam int CW_DEFAULT = 13;

  // Pixel word width for a given byte count.
  function automatic int pix_w(input int bpp);
    return 8 * bpp;
  endfunction

  // Low offset bits that must be zero for a sample to be kept.
  function automatic logic [1:0] decim_mask(input logic [1:0] decim);
    case (decim)
      DECIM_NONE: return 2'b00;
      DECIM_2:    return 2'b01;
      default:    return 2'b11;  // DECIM_4 and DECIM_4_ALT
    endcase
  endfunction

endpackage

// File: rtl/cmos_pix_pack.sv
// Byte-to-pixel packer: shifts DVP bytes in MSB-first and flags each
// completed pixel one cycle after its last byte.
module cmos_pix_pack
  import cmos_cap_pkg::*;
#(
  parameter int BPP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  input  logic             line_end,
  output logic             pix_done,
  output logic [8*BPP-1:0] pix_word,
  output logic             partial
);

  localparam int PIX_W = pix_w(BPP);
  localparam int CNT_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPP - 1);

  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] acc;

  // Byte counter and shift register; a line end drops any partial pixel.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      pix_done <= 1'b0;
    end else begin
      pix_done <= 1'b0;
      if (line_end) begin
        cnt <= '0;
      end else if (byte_valid) begin
        acc <= (acc << 8) | PIX_W'(byte_in);
        if (cnt == CNT_LAST) begin
          cnt      <= '0;
          pix_done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // After BPP shifts the accumulator holds exactly one whole pixel.
  assign pix_word = acc;
  assign partial  = (cnt != '0);

endmodule

// File: rtl/cmos_capture_win.sv
// Camera capture front-end: frame settling, whole-frame capture, run-time
// crop window and decimation, all in the pixel-clock domain.
module cmos_capture_win
  import cmos_cap_pkg::*;
#(
  parameter int BPP         = 2,
  parameter int WAIT_FRAMES = 10,
  parameter int CW          = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  input  logic             enable,
  input  logic [CW-1:0]    crop_x0,
  input  logic [CW-1:0]    crop_y0,
  input  logic [CW-1:0]    crop_w,
  input  logic [CW-1:0]    crop_h,
  input  logic [1:0]       decim,
  output logic             frame_vsync,
  output logic             frame_href,
  output logic             pix_valid,
  output logic [8*BPP-1:0] pix_data,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             line_err
);

  localparam int PIX_W = pix_w(BPP);
  localparam logic [7:0]    WAIT_LAST = 8'(WAIT_FRAMES);
  localparam logic [CW-1:0] X_MAX     = '1;

  // Registered camera inputs and their one-cycle-older copies.
  logic       vs_r, vs_p, hr_r, hr_p;
  logic [7:0] d_r;
  logic       vsync_rise, href_fall;

  // Control state.
  cap_state_t state, state_nxt;
  logic [7:0] wait_cnt;
  logic       run, wait_clr, wait_inc, close_frame, close_q;

  // Per-frame shadow of the window controls.
  logic [CW-1:0] sx0, sy0, sw, sh;
  logic [1:0]    smask;

  // Pixel path.
  logic             pix_done, partial;
  logic [PIX_W-1:0] pix_word;
  logic [CW-1:0]    x, y, dx, dy;
  logic [CW:0]      x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
  logic             in_win, emit;

  // Input stage: one register on every camera signal, plus edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r <= 1'b0;
      vs_p <= 1'b0;
      hr_r <= 1'b0;
      hr_p <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= cam_vsync;
      vs_p <= vs_r;
      hr_r <= cam_href;
      hr_p <= hr_r;
      d_r  <= cam_data;
    end
  end

  assign vsync_rise = vs_r & ~vs_p;
  assign href_fall  = hr_p & ~hr_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; transitions only happen at a frame start.
  // NOTE: the default assignment first keeps this purely combinational;
  // a path that skips state_nxt would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (vsync_rise) begin
      case (state)
        IDLE: if (enable) state_nxt = (WAIT_FRAMES == 0) ? RUN : WAIT;
        WAIT: begin
          if (!enable)                          state_nxt = IDLE;
          else if (wait_cnt + 8'd1 == WAIT_LAST) state_nxt = RUN;
        end
        RUN:  if (!enable) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State-decoded controls.
  always_comb begin
    run         = (state == RUN);
    wait_clr    = (state == IDLE);
    wait_inc    = (state == WAIT);
    close_frame = vsync_rise && (state == RUN);
  end

  // Settling-frame counter, cleared on leaving IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (vsync_rise) begin
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Window controls are frozen at each frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx0   <= '0;
      sy0   <= '0;
      sw    <= '0;
      sh    <= '0;
      smask <= '0;
    end else if (vsync_rise) begin
      sx0   <= crop_x0;
      sy0   <= crop_y0;
      sw    <= crop_w;
      sh    <= crop_h;
      smask <= decim_mask(decim);
    end
  end

  cmos_pix_pack #(.BPP(BPP)) u_pack (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (hr_r),
    .byte_in    (d_r),
    .line_end   (href_fall),
    .pix_done   (pix_done),
    .pix_word   (pix_word),
    .partial    (partial)
  );

  // Window test in CW+1 bits so origin + size cannot wrap.
  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign x_lo   = {1'b0, sx0};
  assign y_lo   = {1'b0, sy0};
  assign x_hi   = x_lo + {1'b0, sw};
  assign y_hi   = y_lo + {1'b0, sh};
  assign dx     = x - sx0;
  assign dy     = y - sy0;
  assign in_win = (x_ext >= x_lo) && (x_ext < x_hi) &&
                  (y_ext >= y_lo) && (y_ext < y_hi) &&
                  ((dx & CW'(smask)) == '0) &&
                  ((dy & CW'(smask)) == '0);
  assign emit   = pix_done && run && in_win;

  // Pixel coordinates; the last pixel of a line is judged before x clears,
  // and the line closes before a coincident frame start clears y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      if (href_fall)                      x <= '0;
      else if (pix_done && (x != X_MAX))  x <= x + CW'(1);

      if (vsync_rise)                                  y <= '0;
      else if (href_fall && ((x != '0) || pix_done))   y <= y + CW'(1);
    end
  end

  // Sticky flag for a line that ended inside a pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        line_err <= 1'b0;
    else if (href_fall && partial)  line_err <= 1'b1;
  end

  // Output stage: pixels and gated syncs share the same two-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      frame_vsync <= 1'b0;
      frame_href  <= 1'b0;
    end else begin
      pix_valid   <= emit;
      if (emit) pix_data <= pix_word;
      frame_vsync <= vs_p && run;
      frame_href  <= hr_p && run;
    end
  end

  // Frame completion, delayed one cycle to line up with frame_vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      close_q    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      close_q    <= close_frame;
      frame_done <= close_q;
      if (close_q) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_win.sv
// Scoreboard bench for cmos_capture_win: a BPP=2 instance with two settling
// frames and a BPP=3 instance that captures immediately.
module tb_cmos_capture_win;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // BPP=2 instance signals.
  logic        cam_vsync = 1'b0, cam_href = 1'b0, enable = 1'b1;
  logic [7:0]  cam_data = '0;
  logic [12:0] crop_x0 = '0, crop_y0 = '0, crop_w = 13'd8, crop_h = 13'd4;
  logic [1:0]  decim = '0;
  logic        frame_vsync, frame_href, pix_valid, frame_done, line_err;
  logic [15:0] pix_data, frame_cnt;

  // BPP=3 instance signals.
  logic        c3_vsync = 1'b0, c3_href = 1'b0, c3_enable = 1'b1;
  logic [7:0]  c3_data = '0;
  logic [12:0] c3_x0 = '0, c3_y0 = '0, c3_w = 13'd8, c3_h = 13'd4;
  logic [1:0]  c3_decim = '0;
  logic        fv3, fh3, pv3, fd3, le3;
  logic [23:0] pd3;
  logic [15:0] fc3;

  cmos_capture_win #(.BPP(2), .WAIT_FRAMES(2), .CW(13)) u_dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(enable), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .crop_w(crop_w), .crop_h(crop_h), .decim(decim),
    .frame_vsync(frame_vsync), .frame_href(frame_href), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_cnt(frame_cnt), .frame_done(frame_done),
    .line_err(line_err)
  );

  cmos_capture_win #(.BPP(3), .WAIT_FRAMES(0), .CW(13)) u_dut3 (
    .clk(clk), .rst(rst), .cam_vsync(c3_vsync), .cam_href(c3_href),
    .cam_data(c3_data), .enable(c3_enable), .crop_x0(c3_x0), .crop_y0(c3_y0),
    .crop_w(c3_w), .crop_h(c3_h), .decim(c3_decim),
    .frame_vsync(fv3), .frame_href(fh3), .pix_valid(pv3),
    .pix_data(pd3), .frame_cnt(fc3), .frame_done(fd3), .line_err(le3)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int mark_cyc = -100;
  int pix_seen = 0, p3_seen = 0, done_seen = 0, seen_base = 0;
  logic [15:0] exp_q[$];
  logic [23:0] q3[$];
  logic [15:0] exp_pix;
  logic [23:0] exp_pix3;
  logic [7:0]  line_a [0:6];
  logic [7:0]  line_b [0:5];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the BPP=2 instance.
  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (pix_valid) begin
      pix_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_pix_valid", 32'(pix_valid), 32'd0);
      end else begin
        exp_pix = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(exp_pix));
        if (exp_pix == 16'hA1B2) check("a1b2_latency", 32'(cyc - mark_cyc), 32'd2);
      end
    end
  end

  // Monitor for the BPP=3 instance.
  always @(negedge clk) begin
    if (pv3) begin
      p3_seen++;
      if (q3.size() == 0) begin
        check("bpp3_spurious_pix_valid", 32'(pv3), 32'd0);
      end else begin
        exp_pix3 = q3.pop_front();
        check("bpp3_pix_data", 32'(pd3), 32'(exp_pix3));
      end
    end
  end

  // Pixel content encodes frame tag, line and column; one pixel is A1,B2.
  function automatic logic [15:0] pword(input int tag, input int x, input int y);
    if (tag == 3 && x == 0 && y == 0) return 16'hA1B2;
    return {4'(tag), 4'(y), 8'(x)};
  endfunction

  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_line(input int tag, input int y);
    logic [15:0] w;
    for (int x = 0; x < 8; x++) begin
      w = pword(tag, x, y);
      cam_href = 1'b1;
      cam_data = w[15:8];
      @(negedge clk);
      cam_data = w[7:0];
      if (tag == 3 && x == 0 && y == 0) mark_cyc = cyc + 1;
      @(negedge clk);
    end
    cam_href = 1'b0;
    cam_data = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_lines(input int tag, input int y_from, input int y_to);
    for (int y = y_from; y <= y_to; y++) drive_line(tag, y);
  endtask

  task automatic expect_win(input int tag, input int x0, input int y0,
                            input int w, input int h, input int step);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        if (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h &&
            ((x - x0) % step) == 0 && ((y - y0) % step) == 0)
          exp_q.push_back(pword(tag, x, y));
  endtask

  task automatic end_frame(input string name, input int n_exp);
    repeat (6) @(negedge clk);
    check({name, "_pix_count"}, 32'(pix_seen - seen_base), 32'(n_exp));
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    seen_base = pix_seen;
  endtask

  task automatic whole_frame(input string name, input int tag, input int n_exp);
    vsync_pulse();
    drive_lines(tag, 0, 3);
    end_frame(name, n_exp);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    line_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    line_b = '{8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_pix_valid",   32'(pix_valid),   32'd0);
    check("rst_pix_data",    32'(pix_data),    32'd0);
    check("rst_frame_vsync", 32'(frame_vsync), 32'd0);
    check("rst_frame_href",  32'(frame_href),  32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    check("rst_frame_cnt",   32'(frame_cnt),   32'd0);
    check("rst_line_err",    32'(line_err),    32'd0);
    check("rst_bpp3_line_err", 32'(le3),       32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // BPP=3: 7-byte line gives 2 pixels and a sticky line error; the next
    // line starts from byte 0.
    q3.push_back(24'h112233);
    q3.push_back(24'h445566);
    q3.push_back(24'h8899AA);
    q3.push_back(24'hBBCCDD);
    c3_vsync = 1'b1;
    repeat (2) @(negedge clk);
    c3_vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      c3_href = 1'b1;
      c3_data = line_a[i];
      @(negedge clk);
    end
    c3_href = 1'b0;
    repeat (5) @(negedge clk);
    check("bpp3_line0_pixels", 32'(p3_seen), 32'd2);
    check("bpp3_line_err_set", 32'(le3), 32'd1);
    for (int i = 0; i < 6; i++) begin
      c3_href = 1'b1;
      c3_data = line_b[i];
      @(negedge clk);
    end
    c3_href = 1'b0;
    repeat (5) @(negedge clk);
    check("bpp3_total_pixels", 32'(p3_seen), 32'd4);
    check("bpp3_line_err_sticky", 32'(le3), 32'd1);
    check("bpp3_queue_drained", 32'(q3.size()), 32'd0);

    // Two settling frames produce nothing.
    whole_frame("f1_wait", 1, 0);
    whole_frame("f2_wait", 2, 0);

    // First captured frame, full window; pixel 0 is A1,B2.
    expect_win(3, 0, 0, 8, 4, 1);
    whole_frame("f3_run", 3, 32);

    // Second captured frame; one completed frame counted at its start.
    expect_win(4, 0, 0, 8, 4, 1);
    vsync_pulse();
    check("f4_start_frame_cnt", 32'(frame_cnt), 32'd1);
    drive_lines(4, 0, 3);
    end_frame("f4_run", 32);

    // Crop 2,1,3,2; a mid-frame change to full window + decim waits a frame.
    crop_x0 = 13'd2; crop_y0 = 13'd1; crop_w = 13'd3; crop_h = 13'd2;
    expect_win(5, 2, 1, 3, 2, 1);
    vsync_pulse();
    check("f5_start_frame_cnt", 32'(frame_cnt), 32'd2);
    drive_line(5, 0);
    crop_x0 = 13'd0; crop_y0 = 13'd0; crop_w = 13'd8; crop_h = 13'd4;
    decim = 2'd1;
    drive_lines(5, 1, 3);
    end_frame("f5_crop", 6);

    // Decimate by 2; enable drops mid-frame but this frame completes.
    expect_win(6, 0, 0, 8, 4, 2);
    vsync_pulse();
    check("f6_start_frame_cnt", 32'(frame_cnt), 32'd3);
    drive_lines(6, 0, 1);
    enable = 1'b0;
    drive_lines(6, 2, 3);
    end_frame("f6_decim", 8);

    // Back to IDLE: no output, but the finished frame is counted.
    vsync_pulse();
    check("f7_start_frame_cnt", 32'(frame_cnt), 32'd4);
    drive_lines(7, 0, 3);
    end_frame("f7_idle", 0);

    // Re-enable with an empty window; two settling frames then RUN.
    enable = 1'b1;
    crop_w = 13'd0;
    decim  = 2'd0;
    whole_frame("f8_wait", 8, 0);
    whole_frame("f9_wait", 9, 0);
    whole_frame("f10_empty", 10, 0);

    // Empty window still closes its frame.
    vsync_pulse();
    check("f11_start_frame_cnt", 32'(frame_cnt), 32'd5);
    check("frame_done_pulses", 32'(done_seen), 32'd5);
    check("main_line_err_clear", 32'(line_err), 32'd0);
    check("last_pix_held", 32'(pix_data), 32'h6206);

    // Reset mid-line clears everything in the same cycle.
    cam_href = 1'b1;
    cam_data = 8'h5A;
    @(negedge clk);
    cam_data = 8'hC3;
    @(negedge clk);
    cam_data = 8'h11;
    @(negedge clk);
    check("href_before_rst", 32'(frame_href), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_pix_valid",   32'(pix_valid),   32'd0);
    check("midrst_pix_data",    32'(pix_data),    32'd0);
    check("midrst_frame_href",  32'(frame_href),  32'd0);
    check("midrst_frame_vsync", 32'(frame_vsync), 32'd0);
    check("midrst_frame_done",  32'(frame_done),  32'd0);
    check("midrst_frame_cnt",   32'(frame_cnt),   32'd0);
    check("midrst_bpp3_line_err", 32'(le3),       32'd0);
    check("midrst_bpp3_pix_data", 32'(pd3),       32'd0);
    cam_href = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
